u13_loader: RTL



---
 rtl/u13_pkg.sv | 37 +++
 rtl/u13_loader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/u13_pkg.sv
// Shared definitions for the u13 boot loader: state encoding, frame defaults
// and small checksum/length helpers.
package u13_pkg;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   localparam int         ADDR_W_DEF    = 16;
   localparam int         STATE_W       = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 3'd0,
      ST_AHI  = 3'd1,
      ST_ALO  = 3'd2,
      ST_LEN  = 3'd3,
      ST_DATA = 3'd4,
      ST_WR   = 3'd5,
      ST_CSUM = 3'd6,
      ST_RUN  = 3'd7
   } state_t;

   // A length byte of zero stands for a full 256-byte block.
   function automatic logic [8:0] len_decode(input logic [7:0] len_byte);
      logic [8:0] len_v;
      if (len_byte == 8'd0) begin
         len_v = 9'd256;
      end else begin
         len_v = {1'b0, len_byte};
      end
      return len_v;
   endfunction

   function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] csum);
      logic [7:0] total_v;
      total_v = sum + csum;
      return (total_v == 8'd0);
   endfunction

endpackage

// File: rtl/u13_loader.sv
// Boot loader: receives a framed image over a byte stream, writes it to RAM
// while holding the CPU in reset, then hands the RAM bus over to the CPU.
module u13_loader
   import u13_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         ADDR_W    = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              cpu_rst,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   input  logic              cpu_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_oe,
   output logic              mem_we,
   output logic              done,
   output logic              err
);

   state_t            state_r;
   logic [15:0]       ptr_r;
   logic [8:0]        cnt_r;
   logic [7:0]        sum_r;
   logic              rx_ready_r;
   logic              cpu_rst_r;
   logic              ld_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [7:0]        mem_wdata_r;
   logic              done_r;
   logic              err_r;
   logic              accept_s;
   logic              run_s;

   assign accept_s = rx_valid & rx_ready_r;
   assign run_s    = (state_r == ST_RUN);

   // Loader FSM; rx_ready is registered alongside the state it belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         ptr_r       <= 16'd0;
         cnt_r       <= 9'd0;
         sum_r       <= 8'd0;
         rx_ready_r  <= 1'b0;
         cpu_rst_r   <= 1'b1;
         ld_we_r     <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= 8'd0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         ld_we_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               rx_ready_r <= 1'b1;
               if (accept_s && (rx_data == SYNC_BYTE)) begin
                  err_r   <= 1'b0;
                  state_r <= ST_AHI;
               end
            end
            ST_AHI: begin
               rx_ready_r <= 1'b1;
               if (accept_s) begin
                  ptr_r[15:8] <= rx_data;
                  state_r     <= ST_ALO;
               end
            end
            ST_ALO: begin
               rx_ready_r <= 1'b1;
               if (accept_s) begin
                  ptr_r[7:0] <= rx_data;
                  state_r    <= ST_LEN;
               end
            end
            ST_LEN: begin
               rx_ready_r <= 1'b1;
               if (accept_s) begin
                  cnt_r   <= len_decode(rx_data);
                  sum_r   <= 8'd0;
                  state_r <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (accept_s) begin
                  mem_wdata_r <= rx_data;
                  mem_addr_r  <= ADDR_W'(ptr_r);
                  sum_r       <= sum_r + rx_data;
                  ld_we_r     <= 1'b1;
                  rx_ready_r  <= 1'b0;
                  state_r     <= ST_WR;
               end else begin
                  rx_ready_r  <= 1'b1;
               end
            end
            ST_WR: begin
               ptr_r      <= ptr_r + 16'd1;
               cnt_r      <= cnt_r - 9'd1;
               rx_ready_r <= 1'b1;
               if (cnt_r == 9'd1) begin
                  state_r <= ST_CSUM;
               end else begin
                  state_r <= ST_DATA;
               end
            end
            ST_CSUM: begin
               if (accept_s && csum_ok(sum_r, rx_data)) begin
                  done_r     <= 1'b1;
                  cpu_rst_r  <= 1'b0;
                  rx_ready_r <= 1'b0;
                  state_r    <= ST_RUN;
               end else if (accept_s) begin
                  err_r      <= 1'b1;
                  rx_ready_r <= 1'b1;
                  state_r    <= ST_IDLE;
               end else begin
                  rx_ready_r <= 1'b1;
               end
            end
            ST_RUN: begin
               rx_ready_r <= 1'b0;
            end
            default: begin
               rx_ready_r <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

   // Once running, the CPU owns the RAM bus with no added latency.
   always_comb begin
      mem_addr  = mem_addr_r;
      mem_wdata = mem_wdata_r;
      mem_we    = ld_we_r;
      if (run_s) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_we    = cpu_we;
      end else begin
         mem_addr  = mem_addr_r;
         mem_wdata = mem_wdata_r;
         mem_we    = ld_we_r;
      end
   end

   assign mem_oe   = mem_we;
   assign rx_ready = rx_ready_r;
   assign cpu_rst  = cpu_rst_r;
   assign done     = done_r;
   assign err      = err_r;

endmodule
